// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: states, opcodes,
// datapath select codes and the ALU-op helper used by the field decoder.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [3:0] {
    OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ILL
  } op_class_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_sel_t;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  // inst[30] picks SRA for both R and I forms, but SUB only for R-type
  function automatic alu_sel_t alu_op(input logic [2:0] f3, input logic alt,
                                      input logic is_reg);
    case (f3)
      3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational decode of the registered instruction into datapath select
// fields, an opcode class, and legality / EBREAK flags.
module inst_field_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic [2:0]  immSel,
  output logic [3:0]  ALUSel,
  output logic        Asel,
  output logic        Bsel,
  output logic [1:0]  WBSel,
  output logic        BrUn,
  output op_class_t   op_class,
  output logic        legal,
  output logic        is_ebreak
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    op_class = OP_ILL;
    immSel   = IMM_I;
    ALUSel   = ALU_ADD;
    Asel     = 1'b0;
    Bsel     = 1'b1;
    WBSel    = WB_ALU;
    BrUn     = 1'b0;
    case (opcode)
      OPC_R: begin
        op_class = OP_R;
        Bsel     = 1'b0;
        ALUSel   = alu_op(funct3, inst[30], 1'b1);
      end
      OPC_IALU: begin
        op_class = OP_IALU;
        ALUSel   = alu_op(funct3, inst[30], 1'b0);
      end
      OPC_LOAD: begin
        op_class = OP_LOAD;
        WBSel    = WB_MEM;
      end
      OPC_STORE: begin
        op_class = OP_STORE;
        immSel   = IMM_S;
      end
      OPC_BRANCH: begin
        op_class = OP_BRANCH;
        immSel   = IMM_B;
        Asel     = 1'b1;
        BrUn     = funct3[1];
      end
      OPC_JAL: begin
        op_class = OP_JAL;
        immSel   = IMM_J;
        Asel     = 1'b1;
        WBSel    = WB_PC4;
      end
      OPC_JALR: begin
        op_class = OP_JALR;
        WBSel    = WB_PC4;
      end
      OPC_LUI: begin
        op_class = OP_LUI;
        immSel   = IMM_U;
        ALUSel   = ALU_PASSB;
      end
      OPC_AUIPC: begin
        op_class = OP_AUIPC;
        immSel   = IMM_U;
        Asel     = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_ebreak = (inst == EBREAK_INST);
  assign legal     = (op_class != OP_ILL) &&
                     !((op_class == OP_BRANCH) && (funct3[2:1] == 2'b01));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath with a single shared memory
// port; halts on EBREAK, illegal instruction or memory timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_isfetch,
  output logic             IRWEn,
  output logic             PCWEn,
  output logic             PCSel,
  output logic             RegWEn,
  output logic [2:0]       immSel,
  output logic             BrUn,
  output logic             Asel,
  output logic             Bsel,
  output logic [3:0]       ALUSel,
  output logic [1:0]       WBSel,
  output logic [2:0]       state,
  output logic             halt,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  state_t      st;
  logic [31:0] wcnt;
  logic        timed_out;
  logic        taken;
  logic        sel_en;

  logic [2:0]  d_immSel;
  logic [3:0]  d_ALUSel;
  logic        d_Asel;
  logic        d_Bsel;
  logic [1:0]  d_WBSel;
  logic        d_BrUn;
  op_class_t   d_op;
  logic        d_legal;
  logic        d_ebreak;

  inst_field_decoder u_dec (
    .inst      (inst),
    .immSel    (d_immSel),
    .ALUSel    (d_ALUSel),
    .Asel      (d_Asel),
    .Bsel      (d_Bsel),
    .WBSel     (d_WBSel),
    .BrUn      (d_BrUn),
    .op_class  (d_op),
    .legal     (d_legal),
    .is_ebreak (d_ebreak)
  );

  assign state = st;

  // wcnt holds completed stall cycles; the stall that would bring it to
  // TIMEOUT halts instead, so a ready in that same cycle still completes.
  assign timed_out = (TIMEOUT != 0) && mem_req && !mem_ready &&
                     (wcnt == TIMEOUT - 1);

  always_comb begin
    taken = 1'b0;
    case (inst[14:12])
      3'b000:         taken = BrEq;
      3'b001:         taken = !BrEq;
      3'b100, 3'b110: taken = BrLt;
      3'b101, 3'b111: taken = !BrLt;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_isfetch = 1'b0;
    IRWEn       = 1'b0;
    PCWEn       = 1'b0;
    PCSel       = 1'b0;
    RegWEn      = 1'b0;
    case (st)
      ST_FETCH: begin
        mem_req     = 1'b1;
        mem_isfetch = 1'b1;
        IRWEn       = mem_ready;
      end
      ST_EXEC: begin
        if (d_op == OP_BRANCH) begin
          PCWEn = 1'b1;
          PCSel = taken;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (d_op == OP_STORE);
        PCWEn   = mem_ready && (d_op == OP_STORE);
      end
      ST_WB: begin
        RegWEn = 1'b1;
        PCWEn  = 1'b1;
        PCSel  = (d_op == OP_JAL) || (d_op == OP_JALR);
      end
      default: ;
    endcase
  end

  assign sel_en = (st != ST_BOOT) && (st != ST_HALT);
  assign immSel = sel_en ? d_immSel : '0;
  assign ALUSel = sel_en ? d_ALUSel : '0;
  assign Asel   = sel_en && d_Asel;
  assign Bsel   = sel_en && d_Bsel;
  assign WBSel  = sel_en ? d_WBSel : '0;
  assign BrUn   = sel_en && d_BrUn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_BOOT;
      wcnt    <= '0;
      instret <= '0;
      halt    <= 1'b0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (st)
        ST_BOOT: begin
          st   <= ST_FETCH;
          wcnt <= '0;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            st <= ST_DECODE;
          end else if (timed_out) begin
            st      <= ST_HALT;
            halt    <= 1'b1;
            bus_err <= 1'b1;
          end else if (TIMEOUT != 0) begin
            wcnt <= wcnt + 32'd1;
          end
        end
        ST_DECODE: begin
          if (d_ebreak) begin
            st   <= ST_HALT;
            halt <= 1'b1;
          end else if (!d_legal) begin
            st      <= ST_HALT;
            halt    <= 1'b1;
            illegal <= 1'b1;
          end else begin
            st <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (d_op)
            OP_BRANCH: begin
              st      <= ST_FETCH;
              wcnt    <= '0;
              instret <= instret + CNT_W'(1);
            end
            OP_LOAD, OP_STORE: begin
              st   <= ST_MEM;
              wcnt <= '0;
            end
            default: st <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (d_op == OP_STORE) begin
              st      <= ST_FETCH;
              wcnt    <= '0;
              instret <= instret + CNT_W'(1);
            end else begin
              st <= ST_WB;
            end
          end else if (timed_out) begin
            st      <= ST_HALT;
            halt    <= 1'b1;
            bus_err <= 1'b1;
          end else if (TIMEOUT != 0) begin
            wcnt <= wcnt + 32'd1;
          end
        end
        ST_WB: begin
          st      <= ST_FETCH;
          wcnt    <= '0;
          instret <= instret + CNT_W'(1);
        end
        ST_HALT: ;
        default: st <= ST_HALT;
      endcase
    end
  end

endmodule
